affine_6tap_stream: RTL

- Streaming 1-D six-tap luma interpolator for affine 1/16-sample motion compensation.
- Successor to the per-tap combinational MCM blocks: all six taps are in one block, input width is parametrised, and the 16-entry fractional phase is selected at run time.
- Adds a sample window shift register, a line-fill counter, valid/ready backpressure and a registered two-stage pipeline.
- Sits between the reference-sample fetch stream and the vertical filter pass.

---
 rtl/affine_6tap_stream.sv | 96 +++++++++
 1 files changed

// File: rtl/affine_6tap_stream.sv
// affine_6tap_stream: six-tap 1/16-phase luma interpolator with valid/ready and a two-stage pipeline.
// Define AFFINE_ROUND_EN to store (sum + 32) >>> 6 instead of the raw scale-64 sum.
module affine_6tap_stream #(
  parameter int IN_W  = 8,
  parameter int OUT_W = IN_W + 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    in_sol,
  input  logic [3:0]              in_frac,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data
);
  logic en, acc, s1_valid, s2_valid;
  logic [2:0] cnt, cnt_nx;
  logic [3:0] frac_reg;
  logic signed [IN_W-1:0] w [6];
  logic signed [OUT_W-1:0] p [6];
  logic signed [OUT_W-1:0] sum, res;

  // Phases 9..15 reuse rows 7..1 with the taps mirrored.
  function automatic logic signed [7:0] coef(input logic [3:0] f, input logic [2:0] k);
    logic [3:0] r;
    logic [2:0] j;
    logic [47:0] row;
    r = (f > 4'd8) ? 4'd0 - f : f;
    j = (f > 4'd8) ? 3'd5 - k : k;
    case (r)
      4'd0:    row = {8'sd0, 8'sd0, 8'sd64, 8'sd0, 8'sd0, 8'sd0};
      4'd1:    row = {8'sd1, -8'sd3, 8'sd63, 8'sd4, -8'sd2, 8'sd1};
      4'd2:    row = {8'sd1, -8'sd5, 8'sd62, 8'sd8, -8'sd3, 8'sd1};
      4'd3:    row = {8'sd2, -8'sd8, 8'sd60, 8'sd13, -8'sd4, 8'sd1};
      4'd4:    row = {8'sd3, -8'sd10, 8'sd58, 8'sd17, -8'sd5, 8'sd1};
      4'd5:    row = {8'sd3, -8'sd11, 8'sd52, 8'sd26, -8'sd8, 8'sd2};
      4'd6:    row = {8'sd2, -8'sd9, 8'sd47, 8'sd31, -8'sd10, 8'sd3};
      4'd7:    row = {8'sd3, -8'sd11, 8'sd45, 8'sd34, -8'sd10, 8'sd3};
      default: row = {8'sd3, -8'sd11, 8'sd40, 8'sd40, -8'sd11, 8'sd3};
    endcase
    return $signed(row[8*(5-j) +: 8]);
  endfunction

  // Shift-and-add on the coefficient magnitude, then negate for negative taps.
  function automatic logic signed [OUT_W-1:0] mul(input logic signed [IN_W-1:0] x, input logic signed [7:0] c);
    logic signed [OUT_W-1:0] xe, a;
    logic [6:0] m;
    xe = OUT_W'(x);
    m = c[7] ? 7'(-c) : c[6:0];
    a = '0;
    for (int b = 0; b < 7; b++)
      if (m[b]) a = a + (xe <<< b);
    return c[7] ? -a : a;
  endfunction

  always_comb begin
    en = !out_valid || out_ready;
    in_ready = en;
    acc = in_valid && en;
    cnt_nx = in_sol ? 3'd1 : (cnt == 3'd6 ? 3'd6 : cnt + 3'd1);
    sum = p[0] + p[1] + p[2] + p[3] + p[4] + p[5];
`ifdef AFFINE_ROUND_EN
    res = (sum + OUT_W'(32)) >>> 6;
`else
    res = sum;
`endif
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) begin
        w[i] <= '0;
        p[i] <= '0;
      end
      cnt <= '0;
      frac_reg <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else if (en) begin
      if (acc) begin
        for (int i = 0; i < 5; i++) w[i] <= w[i+1];
        w[5] <= in_data;
        cnt <= cnt_nx;
        if (in_sol) frac_reg <= in_frac;
      end
      s1_valid <= acc && cnt_nx == 3'd6;
      for (int i = 0; i < 6; i++) p[i] <= mul(w[i], coef(frac_reg, 3'(i)));
      s2_valid <= s1_valid;
      out_data <= res;
      out_valid <= s2_valid;
    end
endmodule
